video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_timing_gen.sv | 179 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Output bundle of the video timing generator: raster counters, syncs,
// strobes and the scaled-window source coordinates.
interface video_timing_gen_if #(
    parameter int CW = 10
);
    logic          pix_ce;
    logic [CW-1:0] DrawX;
    logic [CW-1:0] DrawY;
    logic          hs;
    logic          vs;
    logic          blank;
    logic          line_start;
    logic          frame_start;
    logic          win_active;
    logic [7:0]    win_x;
    logic [7:0]    win_y;

    modport master (
        output pix_ce, DrawX, DrawY, hs, vs, blank,
               line_start, frame_start, win_active, win_x, win_y
    );

    modport slave (
        input  pix_ce, DrawX, DrawY, hs, vs, blank,
               line_start, frame_start, win_active, win_x, win_y
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with clock-enable pixel strobe, registered syncs
// and an integer-upscaled source window mapped onto the active area.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int WIN_W    = 160,
    parameter int WIN_H    = 144,
    parameter int SCALE    = 3,
    parameter int WIN_X0   = 80,
    parameter int WIN_Y0   = 24
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Enable,
    video_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] WX_BEG   = CW'(WIN_X0);
    localparam logic [CW-1:0] WX_END   = CW'(WIN_X0 + WIN_W * SCALE);
    localparam logic [CW-1:0] WY_BEG   = CW'(WIN_Y0);
    localparam logic [CW-1:0] WY_END   = CW'(WIN_Y0 + WIN_H * SCALE);

    generate
        if (!(CLK_DIV >= 1 && SCALE >= 1 && WIN_X0 >= 1 && WIN_Y0 >= 1 &&
              WIN_W <= 256 && WIN_H <= 256 &&
              WIN_X0 + WIN_W * SCALE <= H_ACTIVE &&
              WIN_Y0 + WIN_H * SCALE <= V_ACTIVE &&
              H_TOTAL < (1 << CW) && V_TOTAL < (1 << CW))) begin : g_bad_params
            $error("video_timing_gen: illegal parameter combination");
        end
    endgenerate

    logic [DW-1:0] r_div;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_pix_ce;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_win_active;
    logic [7:0]    r_win_x;
    logic [7:0]    r_wx;
    logic [SW-1:0] r_wx_sub;
    logic [7:0]    r_wy;
    logic [SW-1:0] r_wy_sub;

    logic          w_tick;
    logic [DW-1:0] w_div_next;
    logic          w_x_wrap;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;
    logic          w_hin;
    logic          w_vin;
    logic [7:0]    w_wx_next;
    logic [SW-1:0] w_wx_sub_next;
    logic [7:0]    w_wy_next;
    logic [SW-1:0] w_wy_sub_next;

    assign w_tick     = Enable && (r_div == DIV_LAST);
    assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
    assign w_x_wrap   = (r_x == H_LAST);
    assign w_x_next   = w_x_wrap ? '0 : r_x + CW'(1);
    assign w_y_next   = !w_x_wrap ? r_y : ((r_y == V_LAST) ? '0 : r_y + CW'(1));
    assign w_hin      = (w_x_next >= WX_BEG) && (w_x_next < WX_END);
    assign w_vin      = (w_y_next >= WY_BEG) && (w_y_next < WY_END);

    // Column mapping: DrawX advances by exactly one per tick, so a modulo-SCALE
    // sub-counter restarted on the window's first column replaces a divider.
    always_comb begin
        w_wx_next     = '0;
        w_wx_sub_next = '0;
        if (w_hin && (w_x_next != WX_BEG)) begin
            if (r_wx_sub == SUB_LAST) begin
                w_wx_next = r_wx + 8'd1;
            end else begin
                w_wx_next     = r_wx;
                w_wx_sub_next = r_wx_sub + SW'(1);
            end
        end
    end

    // Row mapping only moves on the line wrap; it reads zero outside window rows.
    always_comb begin
        w_wy_next     = r_wy;
        w_wy_sub_next = r_wy_sub;
        if (w_x_wrap) begin
            w_wy_next     = '0;
            w_wy_sub_next = '0;
            if (w_vin && (w_y_next != WY_BEG)) begin
                if (r_wy_sub == SUB_LAST) begin
                    w_wy_next = r_wy + 8'd1;
                end else begin
                    w_wy_next     = r_wy;
                    w_wy_sub_next = r_wy_sub + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_ce      <= 1'b0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_win_active  <= 1'b0;
            r_win_x       <= '0;
            r_wx          <= '0;
            r_wx_sub      <= '0;
            r_wy          <= '0;
            r_wy_sub      <= '0;
        end else begin
            r_pix_ce      <= w_tick;
            r_line_start  <= w_tick && w_x_wrap;
            r_frame_start <= w_tick && w_x_wrap && (r_y == V_LAST);
            if (Enable) begin
                r_div <= w_div_next;
            end
            if (w_tick) begin
                r_x          <= w_x_next;
                r_y          <= w_y_next;
                r_hs         <= ((w_x_next >= HS_BEG) && (w_x_next < HS_END)) ? HS_POL : ~HS_POL;
                r_vs         <= ((w_y_next >= VS_BEG) && (w_y_next < VS_END)) ? VS_POL : ~VS_POL;
                r_blank      <= (w_x_next < H_ACT) && (w_y_next < V_ACT);
                r_win_active <= w_hin && w_vin;
                r_win_x      <= (w_hin && w_vin) ? w_wx_next : '0;
                r_wx         <= w_wx_next;
                r_wx_sub     <= w_wx_sub_next;
                r_wy         <= w_wy_next;
                r_wy_sub     <= w_wy_sub_next;
            end
        end
    end

    assign vid.pix_ce      = r_pix_ce;
    assign vid.DrawX       = r_x;
    assign vid.DrawY       = r_y;
    assign vid.hs          = r_hs;
    assign vid.vs          = r_vs;
    assign vid.blank       = r_blank;
    assign vid.line_start  = r_line_start;
    assign vid.frame_start = r_frame_start;
    assign vid.win_active  = r_win_active;
    assign vid.win_x       = r_win_x;
    assign vid.win_y       = r_wy;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 28x17 raster with a 5x3
// window scaled by 3, so full frames fit in a short run.
module tb_video_timing_gen;

    localparam int HA  = 20;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VA  = 12;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int DIV = 2;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;
    localparam int CW  = 10;
    localparam int WW  = 5;
    localparam int WH  = 3;
    localparam int SC  = 3;
    localparam int WX0 = 2;
    localparam int WY0 = 1;
    localparam int HT  = HA + HFP + HSW + HBP;   // 28
    localparam int VT  = VA + VFP + VSW + VBP;   // 17

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    logic Enable  = 1'b0;

    video_timing_gen_if #(.CW(CW)) vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(DIV), .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW),
        .WIN_W(WW), .WIN_H(WH), .SCALE(SC), .WIN_X0(WX0), .WIN_Y0(WY0)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Enable  (Enable),
        .vid     (vif)
    );

    always #5 Clk = ~Clk;

    int    checks = 0;
    int    passed = 0;
    int    n      = 0;     // enabled Clk edges since reset release
    bit    last_en = 1'b0;
    int    cyc    = 0;

    function automatic bit m_pce();
        return last_en && (n > 0) && (n % DIV == 0);
    endfunction
    function automatic int m_x();
        return (n / DIV) % HT;
    endfunction
    function automatic int m_y();
        return ((n / DIV) / HT) % VT;
    endfunction
    function automatic bit f_hs(int x);
        return (x >= HA + HFP && x < HA + HFP + HSW) ? HS_POL : !HS_POL;
    endfunction
    function automatic bit f_vs(int y);
        return (y >= VA + VFP && y < VA + VFP + VSW) ? VS_POL : !VS_POL;
    endfunction
    function automatic bit f_rows(int y);
        return (y >= WY0 && y < WY0 + WH * SC);
    endfunction
    function automatic bit f_act(int x, int y);
        return (x >= WX0 && x < WX0 + WW * SC) && f_rows(y);
    endfunction

    task automatic tick(input bit en);
        Enable = en;
        @(posedge Clk);
        if (en) n++;
        last_en = en;
        cyc++;
        #1;
    endtask

    task automatic advance_to(input int x, input int y);
        for (int i = 0; i < 2 * HT * VT * DIV + 4; i++) begin
            if (m_x() == x && m_y() == y && m_pce()) break;
            tick(1'b1);
        end
    endtask

    task automatic release_reset();
        Reset_n = 1'b1;
        n = 0;
        last_en = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Enable  = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (vif.DrawX !== 10'd0) $display("FAIL reset DrawX got %0d want 0", vif.DrawX); else passed++;
        checks++; if (vif.DrawY !== 10'd0) $display("FAIL reset DrawY got %0d want 0", vif.DrawY); else passed++;
        checks++; if (vif.hs !== 1'b0) $display("FAIL reset hs got %b want 0", vif.hs); else passed++;
        checks++; if (vif.vs !== 1'b1) $display("FAIL reset vs got %b want 1", vif.vs); else passed++;
        checks++; if (vif.blank !== 1'b1) $display("FAIL reset blank got %b want 1", vif.blank); else passed++;
        checks++; if (vif.pix_ce !== 1'b0) $display("FAIL reset pix_ce got %b want 0", vif.pix_ce); else passed++;
        checks++; if (vif.line_start !== 1'b0) $display("FAIL reset line_start got %b want 0", vif.line_start); else passed++;
        checks++; if (vif.frame_start !== 1'b0) $display("FAIL reset frame_start got %b want 0", vif.frame_start); else passed++;
        checks++; if (vif.win_active !== 1'b0) $display("FAIL reset win_active got %b want 0", vif.win_active); else passed++;
        checks++; if (vif.win_x !== 8'd0) $display("FAIL reset win_x got %0d want 0", vif.win_x); else passed++;
        checks++; if (vif.win_y !== 8'd0) $display("FAIL reset win_y got %0d want 0", vif.win_y); else passed++;
        $display("reset: DrawX=%0d DrawY=%0d hs=%b vs=%b blank=%b", vif.DrawX, vif.DrawY, vif.hs, vif.vs, vif.blank);
        release_reset();
    endtask

    task automatic test_first_tick();
        tick(1'b1);
        checks++; if (vif.pix_ce !== 1'b0) $display("FAIL first_tick edge1 pix_ce got %b want 0", vif.pix_ce); else passed++;
        checks++; if (vif.DrawX !== 10'd0) $display("FAIL first_tick edge1 DrawX got %0d want 0", vif.DrawX); else passed++;
        tick(1'b1);
        checks++; if (vif.pix_ce !== 1'b1) $display("FAIL first_tick edge2 pix_ce got %b want 1", vif.pix_ce); else passed++;
        checks++; if (vif.DrawX !== 10'd1) $display("FAIL first_tick edge2 DrawX got %0d want 1", vif.DrawX); else passed++;
        checks++; if (vif.line_start !== 1'b0) $display("FAIL first_tick line_start got %b want 0", vif.line_start); else passed++;
        $display("first_tick: pix_ce=%b DrawX=%0d after 2 edges", vif.pix_ce, vif.DrawX);
    endtask

    task automatic test_frame_scan();
        int x, y, errs;
        errs = 0;
        for (int i = 0; i < HT * VT * DIV + 48; i++) begin
            tick(1'b1);
            x = m_x();
            y = m_y();
            checks++; if (vif.DrawX !== CW'(x)) begin $display("FAIL scan DrawX n=%0d got %0d want %0d", n, vif.DrawX, x); errs++; end else passed++;
            checks++; if (vif.DrawY !== CW'(y)) begin $display("FAIL scan DrawY n=%0d got %0d want %0d", n, vif.DrawY, y); errs++; end else passed++;
            checks++; if (vif.pix_ce !== m_pce()) begin $display("FAIL scan pix_ce n=%0d got %b want %b", n, vif.pix_ce, m_pce()); errs++; end else passed++;
            checks++; if (vif.hs !== f_hs(x)) begin $display("FAIL scan hs x=%0d got %b want %b", x, vif.hs, f_hs(x)); errs++; end else passed++;
            checks++; if (vif.vs !== f_vs(y)) begin $display("FAIL scan vs y=%0d got %b want %b", y, vif.vs, f_vs(y)); errs++; end else passed++;
            checks++; if (vif.blank !== (x < HA && y < VA)) begin $display("FAIL scan blank x=%0d y=%0d got %b", x, y, vif.blank); errs++; end else passed++;
            checks++; if (vif.line_start !== (m_pce() && x == 0)) begin $display("FAIL scan line_start n=%0d got %b", n, vif.line_start); errs++; end else passed++;
            checks++; if (vif.frame_start !== (m_pce() && x == 0 && y == 0)) begin $display("FAIL scan frame_start n=%0d got %b", n, vif.frame_start); errs++; end else passed++;
            checks++; if (vif.win_active !== f_act(x, y)) begin $display("FAIL scan win_active x=%0d y=%0d got %b", x, y, vif.win_active); errs++; end else passed++;
            checks++; if (vif.win_x !== (f_act(x, y) ? 8'((x - WX0) / SC) : 8'd0)) begin $display("FAIL scan win_x x=%0d y=%0d got %0d", x, y, vif.win_x); errs++; end else passed++;
            checks++; if (vif.win_y !== (f_rows(y) ? 8'((y - WY0) / SC) : 8'd0)) begin $display("FAIL scan win_y y=%0d got %0d", y, vif.win_y); errs++; end else passed++;
        end
        $display("frame_scan: %0d cycles compared, %0d mismatching fields", HT * VT * DIV + 48, errs);
    endtask

    task automatic test_window();
        int tx[12] = '{1, 2, 3, 4, 5, 16, 17, 3, 10, 16, 5, 0};
        int ty[12] = '{1, 1, 1, 1, 1, 1,  1,  4, 7,  9,  10, 0};
        int ta[12] = '{0, 1, 1, 1, 1, 1,  0,  1, 1,  1,  0,  0};
        int twx[12] = '{0, 0, 0, 0, 1, 4, 0,  0, 2,  4,  0,  0};
        int twy[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 2,  2,  0,  0};
        for (int k = 0; k < 12; k++) begin
            advance_to(tx[k], ty[k]);
            checks++; if (vif.DrawX !== CW'(tx[k]) || vif.DrawY !== CW'(ty[k])) $display("FAIL window pos got (%0d,%0d) want (%0d,%0d)", vif.DrawX, vif.DrawY, tx[k], ty[k]); else passed++;
            checks++; if (vif.win_active !== ta[k][0]) $display("FAIL window active at (%0d,%0d) got %b want %0d", tx[k], ty[k], vif.win_active, ta[k]); else passed++;
            checks++; if (vif.win_x !== 8'(twx[k])) $display("FAIL window win_x at (%0d,%0d) got %0d want %0d", tx[k], ty[k], vif.win_x, twx[k]); else passed++;
            checks++; if (vif.win_y !== 8'(twy[k])) $display("FAIL window win_y at (%0d,%0d) got %0d want %0d", tx[k], ty[k], vif.win_y, twy[k]); else passed++;
            $display("window: (%0d,%0d) active=%b win_x=%0d win_y=%0d", vif.DrawX, vif.DrawY, vif.win_active, vif.win_x, vif.win_y);
        end
    endtask

    task automatic test_periods();
        int t0, t1, f0, f1;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * HT * DIV; i++) begin tick(1'b1); if (vif.line_start === 1'b1) begin found = 1'b1; break; end end
        t0 = cyc;
        tick(1'b1);
        for (int i = 0; i < 4 * HT * DIV && found; i++) begin tick(1'b1); if (vif.line_start === 1'b1) break; end
        t1 = cyc;
        checks++; if (!found || t1 - t0 != HT * DIV) $display("FAIL line_period got %0d want %0d", t1 - t0, HT * DIV); else passed++;
        found = 1'b0;
        for (int i = 0; i < 2 * HT * VT * DIV; i++) begin tick(1'b1); if (vif.frame_start === 1'b1) begin found = 1'b1; break; end end
        f0 = cyc;
        checks++; if (vif.line_start !== 1'b1 || vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) $display("FAIL frame_start_align ls=%b x=%0d y=%0d want 1,0,0", vif.line_start, vif.DrawX, vif.DrawY); else passed++;
        tick(1'b1);
        for (int i = 0; i < 2 * HT * VT * DIV && found; i++) begin tick(1'b1); if (vif.frame_start === 1'b1) break; end
        f1 = cyc;
        checks++; if (!found || f1 - f0 != HT * VT * DIV) $display("FAIL frame_period got %0d want %0d", f1 - f0, HT * VT * DIV); else passed++;
        $display("periods: line=%0d frame=%0d Clk", t1 - t0, f1 - f0);
    endtask

    task automatic test_enable_hold();
        int waited;
        bit seen;
        advance_to(23, 5);
        checks++; if (vif.DrawX !== 10'd23 || vif.hs !== 1'b1) $display("FAIL enable pre x=%0d hs=%b want 23,1", vif.DrawX, vif.hs); else passed++;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            checks++; if (vif.DrawX !== 10'd23) $display("FAIL enable_hold DrawX got %0d want 23", vif.DrawX); else passed++;
            checks++; if (vif.pix_ce !== 1'b0) $display("FAIL enable_hold pix_ce got %b want 0", vif.pix_ce); else passed++;
            checks++; if (vif.hs !== 1'b1) $display("FAIL enable_hold hs got %b want 1", vif.hs); else passed++;
        end
        seen = 1'b0;
        waited = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            waited++;
            if (vif.pix_ce === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || waited != DIV) $display("FAIL enable_resume ticks got %0d want %0d", waited, DIV); else passed++;
        checks++; if (vif.DrawX !== 10'd24) $display("FAIL enable_resume DrawX got %0d want 24", vif.DrawX); else passed++;
        $display("enable: held 50 Clk, resumed at DrawX=%0d after %0d Clk", vif.DrawX, waited);
    endtask

    task automatic test_midframe_reset();
        bit seen;
        advance_to(5, 13);
        checks++; if (vif.vs !== 1'b0) $display("FAIL midreset pre vs got %b want 0", vif.vs); else passed++;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (vif.vs !== 1'b1) $display("FAIL midreset async vs got %b want 1", vif.vs); else passed++;
        checks++; if (vif.DrawX !== 10'd0 || vif.DrawY !== 10'd0) $display("FAIL midreset async pos got (%0d,%0d) want (0,0)", vif.DrawX, vif.DrawY); else passed++;
        checks++; if (vif.hs !== 1'b0 || vif.blank !== 1'b1) $display("FAIL midreset async hs=%b blank=%b want 0,1", vif.hs, vif.blank); else passed++;
        repeat (2) @(posedge Clk);
        #1;
        release_reset();
        seen = 1'b0;
        for (int i = 0; i < 2 * HT * VT * DIV; i++) begin
            tick(1'b1);
            if (vif.vs === 1'b0) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || cyc != (VA + VFP) * HT * DIV) $display("FAIL midreset next_vsync at Clk %0d want %0d", cyc, (VA + VFP) * HT * DIV); else passed++;
        checks++; if (vif.DrawY !== 10'd13 || vif.DrawX !== 10'd0) $display("FAIL midreset vsync pos got (%0d,%0d) want (0,13)", vif.DrawX, vif.DrawY); else passed++;
        $display("midframe_reset: next vsync after %0d Clk at DrawY=%0d", cyc, vif.DrawY);
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_frame_scan();
        test_window();
        test_periods();
        test_enable_hold();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
